// File: rtl/cpu_sequencer_pkg.sv
// Shared constants and types for the CPU fetch/execute sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_sequencer_pkg;

    // Opcodes held in inst[15:12]
    localparam logic [3:0] OP_HALT  = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_STORE = 4'hD;
    localparam logic [3:0] OP_LOAD  = 4'hE;
    localparam logic [3:0] OP_LDI   = 4'hF;

    localparam logic [7:0] RESET_PC_DEF = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_t;

    // Instructions are 16-bit words, so every PC value is an even byte address.
    function automatic logic [7:0] even_addr(input logic [7:0] a);
        return {a[7:1], 1'b0};
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Fetch/execute controller: owns PC, IR and the retired counter; time-shares the single-port memory.
// Latency: 2 cycles per instruction (FETCH then EXEC), no overlap.
// Backpressure: stall freezes FETCH/EXEC and masks mem_we/reg_we; IDLE/HALTED ignore it.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             level; leaves IDLE/HALTED and begins fetching
//   stall             level; holds state/PC/IR/counter and suppresses writes in FETCH/EXEC
//   mem_rdata         combinational memory read data (instruction fetch)
//   data_addr         load/store byte address from the datapath (reg_o1)
//   mem_word          memory word address; mem_we memory write enable
//   inst              IR contents; reg_we register-file write enable
//   pc                current PC byte address; halted high in HALTED; retired instruction count
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter logic [7:0] RESET_PC = RESET_PC_DEF,
    parameter logic [3:0] HALT_OP  = OP_HALT,
    parameter logic [3:0] JMP_OP   = OP_JMP,
    parameter logic [3:0] STORE_OP = OP_STORE,
    parameter logic [3:0] LOAD_OP  = OP_LOAD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    input  logic [15:0] mem_rdata,
    input  logic [7:0]  data_addr,
    output logic [6:0]  mem_word,
    output logic        mem_we,
    output logic [15:0] inst,
    output logic        reg_we,
    output logic [7:0]  pc,
    output logic        halted,
    output logic [15:0] retired
);

    seq_state_t  state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] retired_q, retired_d;
    logic [3:0]  op;

    // Byte lane selection on loads is done in the datapath; only the word address is used here.
    logic unused_data_lsb;
    assign unused_data_lsb = data_addr[0];

    assign op = inst_q[15:12];

    // State register together with the PC/IR/counter it sequences.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= even_addr(RESET_PC);
            inst_q    <= 16'h0000;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (!stall) begin
                    inst_d  = mem_rdata;
                    pc_d    = pc_q + 8'd2;      // wraps FE -> 00
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // The instruction retires only on an unstalled EXEC cycle.
                if (!stall) begin
                    retired_d = retired_q + 16'd1;
                    if (op == JMP_OP) pc_d = even_addr(inst_q[7:0]);
                    state_d = (op == HALT_OP) ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (start) state_d = ST_FETCH;  // resume from the PC after HALT
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from state and IR. Write enables are raw decodes masked by stall,
    // so a reset that leaves EXEC drops them without waiting for a clock.
    always_comb begin
        mem_word = pc_q[7:1];
        mem_we   = 1'b0;
        reg_we   = 1'b0;
        halted   = (state_q == ST_HALTED);
        if (state_q == ST_EXEC) begin
            if (op == STORE_OP) begin
                mem_word = data_addr[7:1];
                mem_we   = !stall;
            end else if (op == LOAD_OP) begin
                mem_word = data_addr[7:1];
                reg_we   = !stall;
            end else if (op != JMP_OP && op != HALT_OP) begin
                reg_we   = !stall;
            end
        end
    end

    assign inst    = inst_q;
    assign pc      = pc_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: table of per-instruction vectors plus hand-written
// stall, resume and reset-abort sequences; a write scoreboard checks every write pulse.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic [15:0] mem_rdata;
    logic [7:0]  data_addr;
    logic [6:0]  mem_word;
    logic        mem_we;
    logic [15:0] inst;
    logic        reg_we;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:127];
    assign mem_rdata = mem[mem_word];

    cpu_sequencer u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .mem_rdata (mem_rdata),
        .data_addr (data_addr),
        .mem_word  (mem_word),
        .mem_we    (mem_we),
        .inst      (inst),
        .reg_we    (reg_we),
        .pc        (pc),
        .halted    (halted),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Store data stands in for reg_o2 (x2 = 2 in the test program).
    always @(posedge clk) begin
        if (mem_we) mem[mem_word] = 16'h0002;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write scoreboard: expected pulses are pushed when an instruction is set up,
    // popped whenever the DUT shows a write enable at a sampling point.
    typedef struct packed {
        logic       mwe;
        logic       rwe;
        logic [6:0] word;
    } wr_t;
    wr_t sb_q [$];
    wr_t sb_exp;

    always @(negedge clk) begin
        if (rst_n && (mem_we || reg_we)) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_write: got we=%b%b word=%0d expected none", mem_we, reg_we, mem_word);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("sb_write", {23'd0, mem_we, reg_we, mem_word}, {23'd0, sb_exp.mwe, sb_exp.rwe, sb_exp.word});
            end
        end
    end

    typedef struct packed {
        logic        first;   // reset + start before this row
        logic [15:0] ins;
        logic [7:0]  daddr;
        logic [7:0]  fpc;     // PC while fetching this instruction
        logic        mwe;
        logic        rwe;
        logic [6:0]  word;    // mem_word during EXEC
        logic [7:0]  npc;     // PC after EXEC
        logic [15:0] ret;     // retired after EXEC
        logic        hlt;     // halted after EXEC
    } vec_t;
    vec_t vecs [11];
    vec_t v;

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        data_addr = 8'h00;
        rst_n = 1'b1;
        start = 1'b0;
        stall = 1'b0;

        //          first ins       daddr  fpc    mwe   rwe   word  npc    ret     hlt
        vecs[0]  = '{1'b1, 16'hF10A, 8'h00, 8'h00, 1'b0, 1'b1, 7'd1, 8'h02, 16'd1, 1'b0};
        vecs[1]  = '{1'b0, 16'hF202, 8'h00, 8'h02, 1'b0, 1'b1, 7'd2, 8'h04, 16'd2, 1'b0};
        vecs[2]  = '{1'b0, 16'h0112, 8'h00, 8'h04, 1'b0, 1'b1, 7'd3, 8'h06, 16'd3, 1'b0};
        vecs[3]  = '{1'b0, 16'hD012, 8'h0C, 8'h06, 1'b1, 1'b0, 7'd6, 8'h08, 16'd4, 1'b0};
        vecs[4]  = '{1'b0, 16'hE310, 8'h0C, 8'h08, 1'b0, 1'b1, 7'd6, 8'h0A, 16'd5, 1'b0};
        vecs[5]  = '{1'b0, 16'hA000, 8'h00, 8'h0A, 1'b0, 1'b0, 7'd6, 8'h0C, 16'd6, 1'b1};
        vecs[6]  = '{1'b1, 16'hC008, 8'h00, 8'h00, 1'b0, 1'b0, 7'd1, 8'h08, 16'd1, 1'b0};
        vecs[7]  = '{1'b0, 16'hA000, 8'h00, 8'h08, 1'b0, 1'b0, 7'd5, 8'h0A, 16'd2, 1'b1};
        vecs[8]  = '{1'b1, 16'hC0FF, 8'h00, 8'h00, 1'b0, 1'b0, 7'd1, 8'hFE, 16'd1, 1'b0};
        vecs[9]  = '{1'b0, 16'hF100, 8'h00, 8'hFE, 1'b0, 1'b1, 7'd0, 8'h00, 16'd2, 1'b0};
        vecs[10] = '{1'b0, 16'hA000, 8'h00, 8'h00, 1'b0, 1'b0, 7'd1, 8'h02, 16'd3, 1'b1};

        // Reset state, and IDLE holds without start.
        do_reset();
        chk("rst_pc", {24'd0, pc}, 32'h00);
        chk("rst_inst", {16'd0, inst}, 32'h0);
        chk("rst_retired", {16'd0, retired}, 32'h0);
        chk("rst_we", {30'd0, mem_we, reg_we}, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'h0);
        @(negedge clk);
        chk("idle_hold_pc", {24'd0, pc}, 32'h00);
        chk("idle_mem_word", {25'd0, mem_word}, 32'h0);

        // Table-driven program execution.
        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            if (v.first) begin
                do_reset();
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            mem[v.fpc[7:1]] = v.ins;
            data_addr = v.daddr;
            chk($sformatf("v%0d_fetch_pc", i), {24'd0, pc}, {24'd0, v.fpc});
            chk($sformatf("v%0d_fetch_word", i), {25'd0, mem_word}, {25'd0, v.fpc[7:1]});
            chk($sformatf("v%0d_fetch_we", i), {30'd0, mem_we, reg_we}, 32'h0);
            if (v.mwe || v.rwe) sb_q.push_back('{v.mwe, v.rwe, v.word});
            @(negedge clk);
            chk($sformatf("v%0d_exec_inst", i), {16'd0, inst}, {16'd0, v.ins});
            chk($sformatf("v%0d_exec_word", i), {25'd0, mem_word}, {25'd0, v.word});
            chk($sformatf("v%0d_exec_we", i), {30'd0, mem_we, reg_we}, {30'd0, v.mwe, v.rwe});
            @(negedge clk);
            chk($sformatf("v%0d_next_pc", i), {24'd0, pc}, {24'd0, v.npc});
            chk($sformatf("v%0d_retired", i), {16'd0, retired}, {16'd0, v.ret});
            chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, v.hlt});
        end
        chk("store_data", {16'd0, mem[6]}, 32'h0002);

        // HALTED holds, then start resumes at the saved PC.
        @(negedge clk);
        chk("halt_hold", {31'd0, halted}, 32'h1);
        chk("halt_hold_pc", {24'd0, pc}, 32'h02);
        mem[1] = 16'hF1FF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("resume_halted", {31'd0, halted}, 32'h0);
        chk("resume_word", {25'd0, mem_word}, 32'd1);
        sb_q.push_back('{1'b0, 1'b1, 7'd2});
        @(negedge clk);
        chk("resume_inst", {16'd0, inst}, 32'hF1FF);
        chk("resume_reg_we", {31'd0, reg_we}, 32'h1);
        @(negedge clk);
        chk("resume_pc", {24'd0, pc}, 32'h04);
        chk("resume_retired", {16'd0, retired}, 32'd4);

        // Stall held three cycles inside EXEC of a store.
        do_reset();
        mem[0] = 16'hD012;
        mem[6] = 16'h0000;
        data_addr = 8'h0C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sb_q.push_back('{1'b1, 1'b0, 7'd6});
        @(posedge clk);
        #1 stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_we", k), {30'd0, mem_we, reg_we}, 32'h0);
            chk($sformatf("stall%0d_inst", k), {16'd0, inst}, 32'hD012);
            chk($sformatf("stall%0d_retired", k), {16'd0, retired}, 32'd0);
            chk($sformatf("stall%0d_pc", k), {24'd0, pc}, 32'h02);
            chk($sformatf("stall%0d_mem", k), {16'd0, mem[6]}, 32'h0000);
        end
        @(posedge clk);
        #1 stall = 1'b0;
        @(negedge clk);
        chk("unstall_mem_we", {31'd0, mem_we}, 32'h1);
        @(negedge clk);
        chk("unstall_after_we", {31'd0, mem_we}, 32'h0);
        chk("unstall_retired", {16'd0, retired}, 32'd1);
        chk("unstall_mem", {16'd0, mem[6]}, 32'h0002);

        // Reset during EXEC of a store aborts it.
        do_reset();
        mem[0] = 16'hD012;
        mem[6] = 16'h1234;
        data_addr = 8'h0C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_pre_we", {31'd0, mem_we}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_mem_we", {31'd0, mem_we}, 32'h0);
        chk("abort_pc", {24'd0, pc}, 32'h00);
        chk("abort_inst", {16'd0, inst}, 32'h0);
        chk("abort_retired", {16'd0, retired}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_mem", {16'd0, mem[6]}, 32'h1234);
        rst_n = 1'b1;
        @(negedge clk);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
